// File: rtl/zeta_pkg.sv
// Shared defaults and state encoding for the zeta moving-average stage.
package zeta_pkg;

  localparam int unsigned WIDTH_DEF      = 20;
  localparam int unsigned DEPTH_LOG2_DEF = 3;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/zeta_window.sv
// Circular sample buffer for zeta: holds the last N accepted samples,
// exposes the entry about to be overwritten and the fill status.
module zeta_window
  import zeta_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    clear,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] oldest,
  output logic                    last,
  output logic                    full
);

  localparam int unsigned N  = 2 ** DEPTH_LOG2;
  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic signed [WIDTH-1:0] ring [N];
  logic [DEPTH_LOG2-1:0]   wr_ptr;
  logic [CW-1:0]           cnt;

  // Entries start at zero so the running-sum subtraction is exact while filling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < N; i++) ring[i] <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (clear) begin
      for (int unsigned i = 0; i < N; i++) ring[i] <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (push) begin
      ring[wr_ptr] <= din;
      wr_ptr       <= wr_ptr + 1'b1;
      if (cnt != CW'(N)) cnt <= cnt + 1'b1;
    end
  end

  assign oldest = ring[wr_ptr];
  assign last   = (cnt == CW'(N - 1));
  assign full   = (cnt == CW'(N));

endmodule

// File: rtl/zeta.sv
// zeta: windowed moving average of the epsilon sample stream, one
// floor-divided average per accepted sample once the window is full.
module zeta
  import zeta_pkg::*;
#(
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [WIDTH-1:0] E_out,
  input  logic                    e_valid,
  output logic                    e_ready,
  input  logic                    flush,
  output logic signed [WIDTH-1:0] Z_out,
  output logic                    z_valid,
  input  logic                    z_ready,
  output logic                    filled
);

  localparam int unsigned AW = WIDTH + DEPTH_LOG2;

  state_t                  state;
  logic signed [AW-1:0]    acc;
  logic signed [AW-1:0]    acc_next;
  logic signed [WIDTH-1:0] avg;
  logic signed [WIDTH-1:0] oldest;
  logic                    last;
  logic                    full;
  logic                    accept;
  logic                    produce;

  zeta_window #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_window (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept),
    .clear   (flush),
    .din     (E_out),
    .oldest  (oldest),
    .last    (last),
    .full    (full)
  );

  // No skid buffer: accept only when the output slot is free or draining.
  assign e_ready  = (!z_valid || z_ready) && !flush;
  assign accept   = e_valid && e_ready;
  // The Nth accept in FILL already produces an output.
  assign produce  = accept && (full || last);
  assign acc_next = acc + AW'(E_out) - AW'(oldest);
  // Arithmetic shift floors toward -inf; the mean always fits in WIDTH.
  assign avg      = WIDTH'(acc_next >>> DEPTH_LOG2);
  assign filled   = (state == RUN);

  // Running sum, FILL/RUN state and registered output handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc     <= '0;
      state   <= FILL;
      Z_out   <= '0;
      z_valid <= 1'b0;
    end else if (flush) begin
      acc     <= '0;
      state   <= FILL;
      z_valid <= 1'b0;
    end else begin
      if (accept) acc <= acc_next;
      if (accept && last) state <= RUN;
      if (produce) begin
        Z_out   <= avg;
        z_valid <= 1'b1;
      end else if (z_ready) begin
        z_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zeta.sv
// Randomized and directed bench for zeta against a queue-based window model.
module tb_zeta;

  localparam int W = 20;
  localparam int D = 3;
  localparam int N = 8;
  localparam int MAXV = 524287;
  localparam int MINV = -524288;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic signed [W-1:0] e_out = '0;
  logic                e_valid = 1'b0;
  logic                e_ready;
  logic                flush = 1'b0;
  logic signed [W-1:0] z_out;
  logic                z_valid;
  logic                z_ready = 1'b1;
  logic                filled;

  always #5 clk = ~clk;

  zeta #(.WIDTH(W), .DEPTH_LOG2(D)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .E_out   (e_out),
    .e_valid (e_valid),
    .e_ready (e_ready),
    .flush   (flush),
    .Z_out   (z_out),
    .z_valid (z_valid),
    .z_ready (z_ready),
    .filled  (filled)
  );

  // Reference model: the window is simply the last N accepted samples.
  int win[$];
  bit m_zv = 1'b0;
  int m_z  = 0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int floor_mean();
    int s = 0;
    foreach (win[i]) s += win[i];
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic cycle(input bit v, input int d, input bit zr, input bit fl);
    bit rdy;
    bit acc;
    bit prod;
    e_valid = v;
    e_out   = W'(d);
    z_ready = zr;
    flush   = fl;
    #1;
    rdy = (!m_zv || zr) && !fl;
    check("e_ready", int'(e_ready), int'(rdy));
    acc = v && rdy;
    @(posedge clk);
    #1;
    prod = 1'b0;
    if (fl) begin
      win.delete();
      m_zv = 1'b0;
    end else begin
      if (acc) begin
        win.push_back(d);
        if (win.size() > N) void'(win.pop_front());
        if (win.size() == N) begin
          m_z  = floor_mean();
          m_zv = 1'b1;
          prod = 1'b1;
        end
      end
      if (!prod && m_zv && zr) m_zv = 1'b0;
    end
    check("z_valid", int'(z_valid), int'(m_zv));
    check("filled", int'(filled), int'(win.size() == N));
    check("z_out", int'(z_out), m_z);
  endtask

  task automatic pulse_reset();
    #2;
    reset_n = 1'b0;
    #1;
    win.delete();
    m_zv = 1'b0;
    m_z  = 0;
    check("rst_z_valid", int'(z_valid), 0);
    check("rst_filled", int'(filled), 0);
    check("rst_z_out", int'(z_out), 0);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic int rnd_sample();
    return int'($urandom_range(0, 1048575)) - 524288;
  endfunction

  initial begin
    int held;
    #3;
    check("reset_z_out", int'(z_out), 0);
    check("reset_z_valid", int'(z_valid), 0);
    check("reset_filled", int'(filled), 0);
    check("reset_e_ready", int'(e_ready), 1);
    #9;
    reset_n = 1'b1;

    // Fill with 1000, then step to -1000.
    for (int i = 0; i < N; i++) cycle(1'b1, 1000, 1'b1, 1'b0);
    check("fill_avg", int'(z_out), 1000);
    for (int i = 0; i < N; i++) begin
      cycle(1'b1, -1000, 1'b1, 1'b0);
      check("step_avg", int'(z_out), 750 - 250 * i);
    end

    // Floor rounding toward -inf.
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < N - 1; i++) cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, -1, 1'b1, 1'b0);
    check("floor_neg", int'(z_out), -1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < N - 1; i++) cycle(1'b1, 0, 1'b1, 1'b0);
    cycle(1'b1, 7, 1'b1, 1'b0);
    check("floor_pos", int'(z_out), 0);

    // Extremes, with wrap-around over a further 2N accepts.
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3 * N; i++) cycle(1'b1, MINV, 1'b1, 1'b0);
    check("ext_min", int'(z_out), MINV);
    cycle(1'b0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 3 * N; i++) cycle(1'b1, MAXV, 1'b1, 1'b0);
    check("ext_max", int'(z_out), MAXV);

    // Back-pressure in RUN: output must hold while z_ready is low.
    cycle(1'b1, rnd_sample(), 1'b1, 1'b0);
    held = m_z;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, rnd_sample(), 1'b0, 1'b0);
      check("bp_hold", int'(z_out), held);
      check("bp_ready", int'(e_ready), 0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b1, rnd_sample(), 1'b1, 1'b0);

    // Flush mid-run with a valid sample present: sample dropped.
    cycle(1'b1, 99999, 1'b1, 1'b1);
    for (int i = 1; i <= N; i++) cycle(1'b1, 8 * i, 1'b1, 1'b0);
    check("flush_avg", int'(z_out), 36);

    // Asynchronous reset mid-run.
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_sample(), 1'b1, 1'b0);
    pulse_reset();
    for (int i = 1; i <= N; i++) cycle(1'b1, i, 1'b1, 1'b0);
    check("reset_avg", int'(z_out), 4);

    // Random traffic with back-pressure, gaps and occasional flushes.
    for (int i = 0; i < 400; i++)
      cycle(($urandom_range(0, 3) != 0), rnd_sample(),
            ($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/zeta.md
# zeta

Windowed moving-average stage downstream of `epsilon`. Consumes the signed 20-bit `E_out` sample stream through a valid/ready handshake and keeps the last 2^DEPTH_LOG2 accepted samples in a circular buffer with a running sum. Once the window is full, it emits one floor-divided window average per accepted sample. The output is registered and supports back-pressure.

## Interface
Parameters:
- WIDTH, 20, sample and average width (signed)
- DEPTH_LOG2, 3, log2 of window length N (N = 8 by default)

Ports:
- clk  in  1  global clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- E_out  in  WIDTH  signed sample from epsilon
- e_valid  in  1  E_out valid
- e_ready  out  1  zeta can accept a sample this cycle
- flush  in  1  synchronous clear of window state
- Z_out  out  WIDTH  signed window average
- z_valid  out  1  Z_out valid
- z_ready  in  1  consumer accepts Z_out
- filled  out  1  window holds N samples (state RUN)

## Operation
- Accept condition: e_valid && e_ready.
- e_ready = (!z_valid || z_ready) && !flush. This is combinational, with no skid buffer.
- Buffer: N registers of WIDTH bits, wr_ptr of DEPTH_LOG2 bits, acc of WIDTH+DEPTH_LOG2 bits (signed), fill counter.
- On accept:
  - acc <= acc + E_out - buf[wr_ptr]
  - buf[wr_ptr] <= E_out
  - wr_ptr increments and wraps from N-1 to 0.
- Buffer entries are zero after reset or flush, so the subtraction is exact during fill.
- FSM has two states:
  - FILL (reset state): accepts update acc and the buffer but produce no output. On the Nth accept, move to RUN and produce an output from that same accept.
  - RUN: every accept produces an output.
- Producing accept: Z_out <= (acc + E_out - buf[wr_ptr]) >>> DEPTH_LOG2, using arithmetic shift (floor toward −inf), and z_valid <= 1.
  - The result always fits in WIDTH, so no saturation logic is needed.
- Output handshake:
  - If z_valid && z_ready and there is no producing accept, then z_valid <= 0.
  - Z_out holds its value while z_valid && !z_ready.
- filled = (state == RUN).
- flush (highest priority after reset) does all of the following in one cycle:
  - zeroes all buffer entries, acc, wr_ptr and the fill counter
  - sets state to FILL
  - sets z_valid <= 0
- Any sample presented while flush is high is not accepted, because e_ready is low.

## Timing
- Reset values: Z_out = 0, z_valid = 0, filled = 0, e_ready = 1 (provided flush = 0).
- Latency is 1 cycle: a producing accept at edge k gives z_valid = 1 with the new Z_out after edge k.
- Throughput is 1 sample per cycle when z_ready is held high.
- Simultaneous output drain and producing accept in the same cycle: z_valid stays 1 and Z_out takes the new value.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first output after release appears only after N new accepts.
- wr_ptr wrap happens on every Nth accept. Running 3N samples must give no drift in acc.

## Structure
- Shared package `zeta_pkg`:
  - default WIDTH and DEPTH_LOG2 constants
  - state enum {FILL, RUN}
- One natural sub-module, `zeta_window`, containing:
  - the circular buffer, wr_ptr and fill counter
  - outputs: the oldest entry (buf[wr_ptr]) and a full flag
- The top level holds acc, the FSM, the divide/shift and the output register.

## Test plan
- Fill: 8 accepts of E_out = 1000 with z_ready = 1 → no z_valid on the first 7. On the 8th accept, Z_out = 1000, z_valid = 1 and filled = 1 one cycle later.
- Step: after the fill above, feed −1000 for 8 accepts → Z_out sequence 750, 500, 250, 0, −250, −500, −750, −1000.
- Floor rounding: window of seven 0s and one −1 → Z_out = −1 (not 0). Window of seven 0s and one +7 → Z_out = 0.
- Extremes:
  - 8× −524288 → Z_out = −524288.
  - 8× 524287 → Z_out = 524287.
  - In both cases acc stays exact across a further 16 accepts (wrap).
- Back-pressure: in RUN, hold z_ready = 0 for 5 cycles with e_valid = 1 → e_ready = 0 and Z_out/z_valid stay stable. On z_ready = 1, exactly one new sample is accepted per cycle and no sample is lost or duplicated.
- Flush/reset mid-run: assert flush for one cycle while e_valid = 1 → z_valid = 0, filled = 0, and that sample is not accepted. The next output appears only after 8 new accepts and equals their average. Repeat the check with reset_n pulsed low mid-cycle.
